// File: rtl/pwm_ctrl_pkg.sv
// Shared definitions for the PWM soft-start sequencer: widths, state encoding
// and the clamped ramp-step helper.
package pwm_ctrl_pkg;

    localparam int STEP_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RAMP     = 3'd1,
        ST_REGULATE = 3'd2,
        ST_FAULT    = 3'd3,
        ST_COOLDOWN = 3'd4
    } state_t;

    // Move cur one increment toward tgt in 17-bit arithmetic, landing exactly on
    // tgt instead of overshooting it or wrapping past either end of 16 bits.
    function automatic logic [STEP_W-1:0] step_toward(
        input logic [STEP_W-1:0] cur,
        input logic [STEP_W-1:0] tgt,
        input logic [STEP_W:0]   inc
    );
        logic [STEP_W:0]   up;
        logic [STEP_W:0]   dn;
        logic [STEP_W-1:0] result;
        up = {1'b0, cur} + inc;
        dn = {1'b0, cur} - inc;
        result = tgt;
        if (cur < tgt) begin
            if (up < {1'b0, tgt}) result = up[STEP_W-1:0];
        end else if (cur > tgt) begin
            // dn[STEP_W] set means the subtraction went below zero.
            if (!dn[STEP_W] && (dn > {1'b0, tgt})) result = dn[STEP_W-1:0];
        end
        return result;
    endfunction

endpackage

// File: rtl/pwm_softstart_sequencer_if.sv
// Bundle between the register bank / PWM generator side and the sequencer.
interface pwm_softstart_sequencer_if;
    import pwm_ctrl_pkg::*;

    // Handshake: start, stop and clear_fault are one-cycle command pulses sampled
    // on the rising clock edge; there is no ready/ack, a pulse that the current
    // state does not accept is dropped. All other signals are levels.
    logic              start;
    logic              stop;
    logic              clear_fault;
    logic              ovp;
    logic [STEP_W-1:0] target_step;
    logic [STEP_W-1:0] target_fb_interval;

    logic [STEP_W-1:0] clock_step;
    logic [STEP_W-1:0] fb_interval;
    logic              gen_run;
    logic [2:0]        state;
    logic              busy;
    logic              fault;

    modport master (
        output start, stop, clear_fault, ovp, target_step, target_fb_interval,
        input  clock_step, fb_interval, gen_run, state, busy, fault
    );

    modport slave (
        input  start, stop, clear_fault, ovp, target_step, target_fb_interval,
        output clock_step, fb_interval, gen_run, state, busy, fault
    );

endinterface

// File: rtl/ovp_debounce.sv
// Over-voltage filter: trips once ovp has been high for OVP_FILTER consecutive
// enabled cycles.
module ovp_debounce #(
    parameter int OVP_FILTER = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    input  logic ovp,
    output logic ovp_trip
);

    localparam int CW = $clog2(OVP_FILTER + 1);
    localparam logic [CW-1:0] LIMIT = CW'(OVP_FILTER);

    logic [CW-1:0] count;

    // Saturates at LIMIT so a long over-voltage cannot wrap back below it.
    always_ff @(posedge clock) begin
        if (reset || !enable || !ovp) begin
            count <= '0;
        end else if (count != LIMIT) begin
            count <= count + 1'b1;
        end
    end

    // Trip comes from the registered count, giving OVP_FILTER+1 cycles from
    // the first high sample to the generator being gated off.
    assign ovp_trip = enable && (count == LIMIT);

endmodule

// File: rtl/pwm_softstart_sequencer.sv
// Sequences the PWM generator: soft-start ramp, slewing to new targets,
// over-voltage fault handling and cooldown before restart is allowed.
module pwm_softstart_sequencer
    import pwm_ctrl_pkg::*;
#(
    parameter int STEP_INC        = 16,
    parameter int RAMP_DIV        = 1024,
    parameter int START_STEP      = 64,
    parameter int OVP_FILTER      = 16,
    parameter int COOLDOWN_CYCLES = 65535
) (
    input logic                       clock,
    input logic                       reset,
    pwm_softstart_sequencer_if.slave  bus
);

    localparam int TW  = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam int CDW = (COOLDOWN_CYCLES > 0) ? $clog2(COOLDOWN_CYCLES + 1) : 1;

    localparam logic [TW-1:0]     TICK_LAST = TW'(RAMP_DIV - 1);
    localparam logic [CDW-1:0]    CD_LOAD   = CDW'(COOLDOWN_CYCLES);
    localparam logic [CDW-1:0]    CD_ONE    = CDW'(1);
    localparam logic [STEP_W-1:0] START_V   = STEP_W'(START_STEP);
    localparam logic [STEP_W:0]   INC_V     = (STEP_W + 1)'(STEP_INC);

    state_t            state_q, state_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [STEP_W-1:0] fb_q, fb_d;
    logic              run_q, run_d;
    logic              busy_q, busy_d;
    logic              fault_q, fault_d;
    logic [TW-1:0]     tick_q, tick_d;
    logic [CDW-1:0]    cool_q, cool_d;

    logic ovp_enable;
    logic ovp_trip;
    logic tick_done;

    assign ovp_enable = (state_q == ST_RAMP) || (state_q == ST_REGULATE);
    assign tick_done  = (tick_q == TICK_LAST);

    ovp_debounce #(
        .OVP_FILTER (OVP_FILTER)
    ) u_ovp (
        .clock    (clock),
        .reset    (reset),
        .enable   (ovp_enable),
        .ovp      (bus.ovp),
        .ovp_trip (ovp_trip)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            step_q  <= '0;
            fb_q    <= '0;
            run_q   <= 1'b0;
            busy_q  <= 1'b0;
            fault_q <= 1'b0;
            tick_q  <= '0;
            cool_q  <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            fb_q    <= fb_d;
            run_q   <= run_d;
            busy_q  <= busy_d;
            fault_q <= fault_d;
            tick_q  <= tick_d;
            cool_q  <= cool_d;
        end
    end

    // Event priority in RAMP/REGULATE: over-voltage trip, then stop, then ramp work.
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        tick_d  = tick_q;
        cool_d  = cool_q;

        case (state_q)
            ST_IDLE: begin
                step_d = '0;
                if (bus.start && !bus.stop) begin
                    state_d = ST_RAMP;
                    step_d  = (bus.target_step < START_V) ? bus.target_step : START_V;
                    tick_d  = '0;
                end
            end

            ST_RAMP: begin
                tick_d = tick_done ? '0 : tick_q + 1'b1;
                if (ovp_trip) begin
                    state_d = ST_FAULT;
                    step_d  = '0;
                end else if (bus.stop) begin
                    state_d = ST_IDLE;
                    step_d  = '0;
                end else if (tick_done) begin
                    if (step_q == bus.target_step) begin
                        state_d = ST_REGULATE;
                    end else begin
                        step_d = step_toward(step_q, bus.target_step, INC_V);
                    end
                end
            end

            ST_REGULATE: begin
                if (ovp_trip) begin
                    state_d = ST_FAULT;
                    step_d  = '0;
                end else if (bus.stop) begin
                    state_d = ST_IDLE;
                    step_d  = '0;
                end else if (bus.target_step != step_q) begin
                    state_d = ST_RAMP;
                    tick_d  = '0;
                end
            end

            ST_FAULT: begin
                step_d = '0;
                if (bus.clear_fault) begin
                    state_d = ST_COOLDOWN;
                    cool_d  = CD_LOAD;
                end
            end

            ST_COOLDOWN: begin
                // Leaves as the count reaches zero: COOLDOWN is visible for
                // exactly COOLDOWN_CYCLES cycles (at least one).
                step_d = '0;
                if (cool_q <= CD_ONE) begin
                    state_d = ST_IDLE;
                    cool_d  = '0;
                end else begin
                    cool_d = cool_q - 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
                step_d  = '0;
                tick_d  = '0;
                cool_d  = '0;
            end
        endcase
    end

    always_comb begin
        run_d   = (state_d == ST_RAMP) || (state_d == ST_REGULATE);
        busy_d  = (state_d == ST_RAMP) || (state_d == ST_COOLDOWN);
        fault_d = (state_d == ST_FAULT);
        fb_d    = run_d ? bus.target_fb_interval : '0;
    end

    assign bus.state       = state_q;
    assign bus.clock_step  = step_q;
    assign bus.fb_interval = fb_q;
    assign bus.gen_run     = run_q;
    assign bus.busy        = busy_q;
    assign bus.fault       = fault_q;

endmodule

// File: tb/tb_pwm_softstart_sequencer.sv
// Directed bench for pwm_softstart_sequencer with RAMP_DIV=4, OVP_FILTER=3,
// COOLDOWN_CYCLES=5.
module tb_pwm_softstart_sequencer;

    localparam logic [2:0]  S_IDLE = 3'd0;
    localparam logic [2:0]  S_RAMP = 3'd1;
    localparam logic [2:0]  S_REG  = 3'd2;
    localparam logic [2:0]  S_FLT  = 3'd3;
    localparam logic [2:0]  S_COOL = 3'd4;
    localparam logic [15:0] FB     = 16'h0123;

    logic clock = 1'b0;
    logic reset;
    int   compared   = 0;
    int   mismatched = 0;

    pwm_softstart_sequencer_if bus();

    pwm_softstart_sequencer #(
        .STEP_INC        (16),
        .RAMP_DIV        (4),
        .START_STEP      (64),
        .OVP_FILTER      (3),
        .COOLDOWN_CYCLES (5)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        string       name;
        logic        start;
        logic        stop;
        logic        clear_fault;
        logic [15:0] target;
        int          cycles;
        logic [2:0]  exp_state;
        logic [15:0] exp_step;
    } vec_t;

    vec_t vecs[$];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_eq(input string name, input logic [15:0] actual, input logic [15:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic check_state(input string name, input logic [2:0] es, input logic [15:0] estep);
        logic active;
        active = (es == S_RAMP) || (es == S_REG);
        check_eq({name, ".state"}, 16'(bus.state), 16'(es));
        check_eq({name, ".clock_step"}, bus.clock_step, estep);
        check_eq({name, ".gen_run"}, 16'(bus.gen_run), 16'(active));
        check_eq({name, ".busy"}, 16'(bus.busy), 16'((es == S_RAMP) || (es == S_COOL)));
        check_eq({name, ".fault"}, 16'(bus.fault), 16'(es == S_FLT));
        if (active) check_eq({name, ".fb_interval"}, bus.fb_interval, FB);
    endtask

    task automatic add(input string name, input logic st, input logic sp, input logic cf,
                       input logic [15:0] tgt, input int n, input logic [2:0] es, input logic [15:0] estep);
        vec_t v;
        v.name = name; v.start = st; v.stop = sp; v.clear_fault = cf;
        v.target = tgt; v.cycles = n; v.exp_state = es; v.exp_step = estep;
        vecs.push_back(v);
    endtask

    task automatic apply_vec(input vec_t v);
        bus.start       = v.start;
        bus.stop        = v.stop;
        bus.clear_fault = v.clear_fault;
        bus.target_step = v.target;
        tick();
        bus.start       = 1'b0;
        bus.stop        = 1'b0;
        bus.clear_fault = 1'b0;
        for (int i = 1; i < v.cycles; i++) tick();
        check_state(v.name, v.exp_state, v.exp_step);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        // name, start, stop, clear, target, cycles, state, step
        add("soft_start",    1, 0, 0, 128, 1, S_RAMP, 64);
        add("ss_hold",       0, 0, 0, 128, 3, S_RAMP, 64);
        add("ss_80",         0, 0, 0, 128, 1, S_RAMP, 80);
        add("ss_96",         0, 0, 0, 128, 4, S_RAMP, 96);
        add("ss_112",        0, 0, 0, 128, 4, S_RAMP, 112);
        add("ss_128",        0, 0, 0, 128, 4, S_RAMP, 128);
        add("ss_128_hold",   0, 0, 0, 128, 3, S_RAMP, 128);
        add("ss_regulate",   0, 0, 0, 128, 1, S_REG,  128);
        add("clr_in_reg",    0, 0, 1, 128, 1, S_REG,  128);
        add("retarget",      0, 0, 0, 90,  1, S_RAMP, 128);
        add("rt_hold",       0, 0, 0, 90,  3, S_RAMP, 128);
        add("rt_112",        0, 0, 0, 90,  1, S_RAMP, 112);
        add("rt_96",         0, 0, 0, 90,  4, S_RAMP, 96);
        add("rt_90",         0, 0, 0, 90,  4, S_RAMP, 90);
        add("rt_regulate",   0, 0, 0, 90,  4, S_REG,  90);
        add("stop_reg",      0, 1, 0, 90,  1, S_IDLE, 0);
        add("clamp_start",   1, 0, 0, 100, 1, S_RAMP, 64);
        add("clamp_80",      0, 0, 0, 100, 4, S_RAMP, 80);
        add("clamp_96",      0, 0, 0, 100, 4, S_RAMP, 96);
        add("clamp_100",     0, 0, 0, 100, 4, S_RAMP, 100);
        add("clamp_reg",     0, 0, 0, 100, 4, S_REG,  100);
        add("stop_clamp",    0, 1, 0, 100, 1, S_IDLE, 0);
        add("start_stop",    1, 1, 0, 100, 1, S_IDLE, 0);
        add("clr_in_idle",   0, 0, 1, 100, 1, S_IDLE, 0);
        add("low_target",    1, 0, 0, 20,  1, S_RAMP, 20);
        add("low_reg",       0, 0, 0, 20,  4, S_REG,  20);
        add("stop_low",      0, 1, 0, 20,  1, S_IDLE, 0);

        reset                  = 1'b1;
        bus.start              = 1'b0;
        bus.stop               = 1'b0;
        bus.clear_fault        = 1'b0;
        bus.ovp                = 1'b0;
        bus.target_step        = 16'd128;
        bus.target_fb_interval = FB;
        tick();
        tick();
        reset = 1'b0;
        check_state("reset", S_IDLE, 0);
        check_eq("reset.fb_interval", bus.fb_interval, 16'd0);

        foreach (vecs[i]) apply_vec(vecs[i]);

        // OVP filter: a 2-cycle burst is absorbed, 3 consecutive highs trip.
        bus.target_step = 16'd128;
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        check_state("ovp_start", S_RAMP, 64);
        bus.ovp = 1'b1; tick(); tick();
        bus.ovp = 1'b0; tick();
        check_eq("ovp_burst.state", 16'(bus.state), 16'(S_RAMP));
        check_eq("ovp_burst.fault", 16'(bus.fault), 16'd0);
        bus.ovp = 1'b1; tick(); tick(); tick();
        check_eq("ovp_3high.gen_run", 16'(bus.gen_run), 16'd1);
        bus.ovp = 1'b0; tick();
        check_state("ovp_trip", S_FLT, 0);
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        check_state("fault_start", S_FLT, 0);
        bus.stop = 1'b1; tick(); bus.stop = 1'b0;
        check_state("fault_stop", S_FLT, 0);

        // Cooldown with ovp held high (not monitored) and a start pulse mid-way.
        bus.ovp = 1'b1;
        bus.clear_fault = 1'b1; tick(); bus.clear_fault = 1'b0;
        check_state("cool_enter", S_COOL, 0);
        for (int i = 1; i < 5; i++) begin
            if (i == 2) bus.start = 1'b1;
            tick();
            bus.start = 1'b0;
            check_state($sformatf("cool_%0d", i), S_COOL, 0);
        end
        tick();
        check_state("cool_done", S_IDLE, 0);
        tick();
        check_state("cool_no_start", S_IDLE, 0);
        bus.ovp = 1'b0;

        // Stop arriving in the same cycle as the trip loses to the fault.
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        bus.ovp = 1'b1; tick(); tick(); tick();
        bus.ovp = 1'b0; bus.stop = 1'b1; tick(); bus.stop = 1'b0;
        check_state("stop_vs_trip", S_FLT, 0);
        bus.clear_fault = 1'b1; tick(); bus.clear_fault = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check_state("recover_idle", S_IDLE, 0);

        // Reset in the middle of a ramp.
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        tick(); tick();
        check_eq("pre_reset.state", 16'(bus.state), 16'(S_RAMP));
        reset = 1'b1; tick();
        check_state("reset_mid", S_IDLE, 0);
        check_eq("reset_mid.fb_interval", bus.fb_interval, 16'd0);
        reset = 1'b0; tick();
        check_state("after_reset", S_IDLE, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
